// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared types and constants for the demux dispatch controller.
package demux_dispatch_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = $clog2(NUM_CH);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TMR_W  = 8;

    // Control half of the holding register; payload width is a top-level parameter.
    typedef struct packed {
        logic [CH_W-1:0] dest;
        logic            rr;
    } hold_ctl_t;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction

endpackage

// File: rtl/dispatch_timer.sv
// Stall counter: counts enabled cycles and signals expiry on reaching TIMEOUT, then restarts.
module dispatch_timer
    import demux_dispatch_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Expiry is flagged on the cycle whose increment would reach TIMEOUT.
    assign expire_o = en_i && (cnt_q == TMR_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// One-beat demux: routes each accepted beat to an addressed or round-robin channel,
// re-targeting (round-robin) or dropping (addressed) beats that stall for TIMEOUT cycles.
module demux_dispatch_ctrl
    import demux_dispatch_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_dest,
    input  logic              mode,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   select_line,
    output logic              drop,
    output logic [CNT_W-1:0]  deliver_cnt
);

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] data_q;
    hold_ctl_t         ctl_q;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [CH_W-1:0]   rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy;
    logic              deliver;
    logic              expire;
    logic              accept;
    logic              rr_adv;

    assign busy    = (state_q == BUSY);
    assign deliver = busy && out_ready[ctl_q.dest];
    assign accept  = in_valid && in_ready;
    assign rr_adv  = busy && expire && ctl_q.rr;

    // A beat accepted in the same cycle as a round-robin delivery sees the advanced pointer.
    assign rr_ptr_d = (deliver && ctl_q.rr) ? ctl_q.dest + CH_W'(1) : rr_ptr_q;

    dispatch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (accept),
        .en_i     (busy && !deliver),
        .expire_o (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (deliver || drop) state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; expire already excludes delivery cycles, so delivery wins.
    always_comb begin
        drop      = 1'b0;
        in_ready  = 1'b1;
        out_valid = '0;
        if (busy) begin
            drop      = expire && !ctl_q.rr && !rst;
            in_ready  = deliver || drop;
            out_valid = ch_onehot(ctl_q.dest);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            ctl_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                data_q     <= in_data;
                ctl_q.rr   <= mode;
                ctl_q.dest <= mode ? rr_ptr_d : in_dest;
            end else if (rr_adv) begin
                ctl_q.dest <= ctl_q.dest + CH_W'(1);
            end
            if (deliver) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_data    = data_q;
    assign select_line = ctl_q.dest;
    assign deliver_cnt = cnt_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Scoreboard bench for demux_dispatch_ctrl: expected deliveries queued at accept, checked on output.
module tb_demux_dispatch_ctrl;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TIMEOUT = 15;

    typedef struct packed {
        logic [1:0]        ch;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_dest;
    logic              mode;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        select_line;
    logic              drop;
    logic [15:0]       deliver_cnt;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    exp_t e_pop;

    always #5 clk = ~clk;

    demux_dispatch_ctrl #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_dest     (in_dest),
        .mode        (mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .select_line (select_line),
        .drop        (drop),
        .deliver_cnt (deliver_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Present a beat until accepted; queue its expected delivery if one is due.
    task automatic drive_beat(input logic m, input logic [1:0] d, input logic [DATA_W-1:0] data,
                              input bit exp_del, input logic [1:0] exp_ch, output int waits);
        in_valid = 1'b1;
        mode     = m;
        in_dest  = d;
        in_data  = data;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'(1));
        else if (exp_del) sb.push_back('{ch: exp_ch, data: data});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && ((out_valid & out_ready) != 4'b0000)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 32'(out_valid), 32'(0));
            end else begin
                e_pop = sb.pop_front();
                check("sb_chan", 32'(select_line), 32'(e_pop.ch));
                check("sb_onehot", 32'(out_valid), 32'(4'b0001 << e_pop.ch));
                check("sb_data", 32'(out_data), 32'(e_pop.data));
            end
        end
    end

    initial begin
        int w;
        int first_k;
        int n_drop;
        int del_k;
        logic ir15;
        logic [1:0] sel_hist [1:40];
        logic [1:0] rr_m;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0; mode = 1'b0; out_ready = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_select", 32'(select_line), 32'(0));
        check("rst_drop", 32'(drop), 32'(0));
        check("rst_cnt", 32'(deliver_cnt), 32'(0));
        @(posedge clk); #1;

        // Addressed beat to channel 2
        out_ready = 4'b1111;
        drive_beat(1'b0, 2'd2, 8'hA5, 1'b1, 2'd2, w);
        @(negedge clk);
        check("addr_valid", 32'(out_valid), 32'(4'b0100));
        check("addr_data", 32'(out_data), 32'(8'hA5));
        @(negedge clk);
        check("addr_cnt", 32'(deliver_cnt), 32'(1));
        check("addr_idle_valid", 32'(out_valid), 32'(0));
        check("addr_hold_sel", 32'(select_line), 32'(2));
        @(posedge clk); #1;

        // Round-robin, 5 beats, all ready: channels 0,1,2,3,0
        rr_m = 2'd0;
        for (int i = 0; i < 5; i++) begin
            drive_beat(1'b1, 2'd3, DATA_W'(8'h10 + i), 1'b1, rr_m, w);
            check("rr_no_wait", 32'(w), 32'(0));
            rr_m = rr_m + 2'd1;
        end
        repeat (2) @(posedge clk); #1;

        // Back-to-back addressed beats
        for (int i = 0; i < 4; i++) begin
            logic [1:0] d;
            d = 2'(3 - i);
            drive_beat(1'b0, d, DATA_W'(8'hC0 + i), 1'b1, d, w);
            check("b2b_no_wait", 32'(w), 32'(0));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("b2b_cnt", 32'(deliver_cnt), 32'(10));
        @(posedge clk); #1;

        // Addressed stall: drop on the TIMEOUT-th busy cycle
        out_ready = 4'b0000;
        drive_beat(1'b0, 2'd1, 8'h77, 1'b0, 2'd0, w);
        first_k = 0; n_drop = 0; ir15 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (drop) begin
                if (first_k == 0) first_k = k;
                n_drop++;
            end
            if (k == int'(TIMEOUT)) ir15 = in_ready;
            if (k == int'(TIMEOUT) + 1) check("drop_idle_valid", 32'(out_valid), 32'(0));
        end
        check("drop_cycle", 32'(first_k), 32'(TIMEOUT));
        check("drop_count", 32'(n_drop), 32'(1));
        check("drop_in_ready", 32'(ir15), 32'(1));
        @(posedge clk); #1;

        // Reset while busy
        drive_beat(1'b0, 2'd0, 8'h55, 1'b0, 2'd0, w);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rstb_drop_during", 32'(drop), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstb_valid", 32'(out_valid), 32'(0));
        check("rstb_cnt", 32'(deliver_cnt), 32'(0));
        check("rstb_drop", 32'(drop), 32'(0));
        check("rstb_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk); #1;

        // Round-robin stall: 0 -> 1 -> 2, delivered on channel 2
        out_ready = 4'b0100;
        drive_beat(1'b1, 2'd0, 8'h3C, 1'b1, 2'd2, w);
        del_k = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            sel_hist[k] = select_line;
            if (((out_valid & out_ready) != 4'b0000) && del_k == 0) del_k = k;
        end
        check("rrto_sel_15", 32'(sel_hist[15]), 32'(0));
        check("rrto_sel_16", 32'(sel_hist[16]), 32'(1));
        check("rrto_sel_30", 32'(sel_hist[30]), 32'(1));
        check("rrto_sel_31", 32'(sel_hist[31]), 32'(2));
        check("rrto_del_cycle", 32'(del_k), 32'(31));
        check("rrto_cnt", 32'(deliver_cnt), 32'(1));
        @(posedge clk); #1;

        // Delivery coinciding with timeout: delivery wins
        out_ready = 4'b0000;
        drive_beat(1'b0, 2'd3, 8'hE1, 1'b1, 2'd3, w);
        repeat (14) @(posedge clk);
        #1 out_ready = 4'b1000;
        @(negedge clk);
        check("coin_drop", 32'(drop), 32'(0));
        check("coin_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1 out_ready = 4'b0000;
        @(negedge clk);
        check("coin_cnt", 32'(deliver_cnt), 32'(2));
        check("coin_idle_valid", 32'(out_valid), 32'(0));

        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_dispatch_ctrl.md
DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the stall limit in cycles (legal range 1..255).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: the upstream beat is present.
REQ-006 Port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-007 Port in_data, input, DATA_W bits: the payload.
REQ-008 Port in_dest, input, 2 bits: the target output in addressed mode.
REQ-009 Port mode, input, 1 bit: 0 selects addressed mode, 1 selects round-robin mode.
REQ-010 Port out_valid, output, 4 bits: one-hot valid, one bit per output channel.
REQ-011 Port out_ready, input, 4 bits: per-channel ready.
REQ-012 Port out_data, output, DATA_W bits: the payload, shared by all channels.
REQ-013 Port select_line, output, 2 bits: the channel currently driven.
REQ-014 Port drop, output, 1 bit: a one-cycle pulse when a beat is discarded.
REQ-015 Port deliver_cnt, output, 16 bits: the number of delivered beats, wrapping.

Function
REQ-016 The FSM SHALL have two states, IDLE and BUSY.
REQ-017 In IDLE, in_ready SHALL be 1.
REQ-018 In BUSY, in_ready SHALL be 1 only in a cycle where the held beat completes delivery or is dropped; this is a combinational path from out_ready.
REQ-019 Accept (in_valid & in_ready) SHALL capture in_data, the destination and mode into a holding register, and the state SHALL be BUSY next cycle.
REQ-020 The destination captured on accept SHALL be in_dest when mode=0, and the round-robin pointer rr_ptr when mode=1.
REQ-021 Latency: a beat accepted at cycle N SHALL have out_valid asserted at cycle N+1.
REQ-022 In BUSY, out_valid SHALL be one-hot at the held destination, select_line SHALL equal that destination, and out_data SHALL equal the held data.
REQ-023 In IDLE, out_valid SHALL be 4'b0000 and out_data/select_line SHALL hold their last values.
REQ-024 Delivery SHALL occur when out_valid[d] & out_ready[d]; on delivery, deliver_cnt SHALL increment, wrapping from 16'hFFFF to 0.
REQ-025 After delivery the next state SHALL be BUSY if a new accept happens in the same cycle, otherwise IDLE.
REQ-026 On delivery of a round-robin beat, rr_ptr SHALL advance to destination+1 mod 4; addressed beats SHALL NOT move rr_ptr.
REQ-027 The stall counter SHALL clear on accept and increment on each BUSY cycle without delivery.
REQ-028 When the stall counter reaches TIMEOUT on a round-robin beat, the destination SHALL advance by 1 mod 4, the counter SHALL clear, and the beat SHALL be retained.
REQ-029 When the stall counter reaches TIMEOUT on an addressed beat, the beat SHALL be discarded, drop SHALL pulse for 1 cycle, and the state SHALL go to IDLE (or BUSY if a new accept happens in the same cycle).
REQ-030 The mode input SHALL be sampled only at accept; changing mode during BUSY SHALL NOT affect the held beat.
REQ-031 When delivery and timeout coincide in the same cycle, delivery SHALL win and drop SHALL NOT pulse.

Reset
REQ-032 rst SHALL take priority over all other inputs.
REQ-033 Next cycle after reset: state=IDLE, out_valid=0, in_ready=1, out_data=0, select_line=0, drop=0, deliver_cnt=0, rr_ptr=0, stall counter=0.
REQ-034 A held beat SHALL be discarded on reset without a drop pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding (IDLE=1'b0, BUSY=1'b1), the channel count 4, and the width of deliver_cnt.
REQ-036 One sub-module, dispatch_timer, SHALL hold the stall counter, with clear/enable inputs and an expire output.

Verification
REQ-037 Addressed mode, in_dest=2, data 8'hA5, out_ready=4'b1111 -> out_valid=4'b0100 and out_data=8'hA5 one cycle after accept; deliver_cnt=1.
REQ-038 Round-robin mode, 5 beats, all outputs ready -> select_line sequence 0,1,2,3,0.
REQ-039 Addressed mode, in_dest=1, out_ready=0 -> drop pulses at the TIMEOUT-th BUSY cycle (cycle 15 at default) and the state returns to IDLE.
REQ-040 Round-robin mode, out_ready=4'b0100 -> the beat moves 0 -> 1 -> 2 at 15-cycle intervals and is delivered on channel 2.
REQ-041 Back-to-back beats with out_ready held high -> in_ready stays high and one beat is delivered per cycle after the first.
REQ-042 rst asserted while BUSY -> next cycle out_valid=0, deliver_cnt=0, and drop stays 0.
